// File: rtl/regfile_pkg.sv
// Shared constants and types for the tri-state register file.
// Holds default geometry, the hardwired-zero index and data/address types.
package regfile_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_REGS   = 32;
    localparam int ZERO_REG      = 0;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_tri_if.sv
// Register file access bundle: one write port, two read ports.
// master = decode/writeback side, slave = register file.
interface regfile_tri_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/decoder_onehot.sv
// Enable-gated binary to one-hot decoder.
// Ports: en, addr[ADDR_WIDTH] in; y[2**ADDR_WIDTH] out, all zero when en=0.
module decoder_onehot
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                     en,
    input  logic [ADDR_WIDTH-1:0]    addr,
    output logic [2**ADDR_WIDTH-1:0] y
);
    always_comb begin
        y       = '0;
        y[addr] = en;
    end
endmodule

// File: rtl/regfile_tri.sv
// Register file: 1 sync write, 2 comb reads over tri-state row buses, r0=0.
// Ports: clk, clr (async, active-high), rf (regfile_tri_if.slave).
// Option: REGFILE_BYPASS_EN forwards same-cycle wdata to matching reads.
module regfile_tri
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          clr,
    regfile_tri_if.slave  rf
);
    localparam int NDEC = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] NREG = NUM_REGS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] RZ = ZERO_REG[ADDR_WIDTH-1:0];

    logic [NDEC-1:0] wsel;
    logic [NDEC-1:0] asel;
    logic [NDEC-1:0] bsel;
    logic            zero_a;
    logic            zero_b;

    wire [DATA_WIDTH-1:0] bus_a;
    wire [DATA_WIDTH-1:0] bus_b;

    decoder_onehot #(.ADDR_WIDTH(ADDR_WIDTH)) u_wdec (
        .en   (rf.we),
        .addr (rf.waddr),
        .y    (wsel)
    );

    decoder_onehot #(.ADDR_WIDTH(ADDR_WIDTH)) u_adec (
        .en   (1'b1),
        .addr (rf.raddr_a),
        .y    (asel)
    );

    decoder_onehot #(.ADDR_WIDTH(ADDR_WIDTH)) u_bdec (
        .en   (1'b1),
        .addr (rf.raddr_b),
        .y    (bsel)
    );

    // r0 and indices with no backing row share the zero driver,
    // so each bus always has exactly one active driver.
    assign zero_a = (rf.raddr_a == RZ) || ({1'b0, rf.raddr_a} >= NREG);
    assign zero_b = (rf.raddr_b == RZ) || ({1'b0, rf.raddr_b} >= NREG);

    assign bus_a = zero_a ? '0 : 'z;
    assign bus_b = zero_b ? '0 : 'z;

    // Rows exist only for 1..NUM_REGS-1; writes elsewhere hit nothing.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_row
        logic [DATA_WIDTH-1:0] q;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                q <= '0;
            end else if (wsel[i]) begin
                q <= rf.wdata;
            end
        end

        assign bus_a = asel[i] ? q : 'z;
        assign bus_b = bsel[i] ? q : 'z;
    end

    // Decode bit 0 and bits past the last row have no consumer.
    logic unused_sel;
    assign unused_sel = ^{wsel, asel, bsel};

`ifdef REGFILE_BYPASS_EN
    logic byp_a;
    logic byp_b;

    assign byp_a = rf.we && !clr && !zero_a
                && (rf.raddr_a == rf.waddr);
    assign byp_b = rf.we && !clr && !zero_b
                && (rf.raddr_b == rf.waddr);

    assign rf.rdata_a = byp_a ? rf.wdata : bus_a;
    assign rf.rdata_b = byp_b ? rf.wdata : bus_b;
`else
    assign rf.rdata_a = bus_a;
    assign rf.rdata_b = bus_b;
`endif

endmodule

// File: tb/tb_regfile_tri.sv
// Randomized bench for regfile_tri against an array model.
// Runs a 32-row and a 24-row instance on shared stimulus.
module tb_regfile_tri;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;

    always #5 clk = ~clk;

    regfile_tri_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if32 ();
    regfile_tri_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if24 ();

    assign if32.we      = we;
    assign if32.waddr   = waddr;
    assign if32.wdata   = wdata;
    assign if32.raddr_a = ra;
    assign if32.raddr_b = rb;
    assign if24.we      = we;
    assign if24.waddr   = waddr;
    assign if24.wdata   = wdata;
    assign if24.raddr_a = ra;
    assign if24.raddr_b = rb;

    regfile_tri #(
        .DATA_WIDTH (32),
        .NUM_REGS   (32),
        .ADDR_WIDTH (5)
    ) dut32 (
        .clk (clk),
        .clr (clr),
        .rf  (if32)
    );

    regfile_tri #(
        .DATA_WIDTH (32),
        .NUM_REGS   (24),
        .ADDR_WIDTH (5)
    ) dut24 (
        .clk (clk),
        .clr (clr),
        .rf  (if24)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    logic [31:0] m32 [32];
    logic [31:0] m24 [32];

    // Model: a plain array per instance, cleared by clr, written on edges.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                m32[i] <= 32'h0;
                m24[i] <= 32'h0;
            end
        end else if (we && waddr != 5'd0) begin
            m32[waddr] <= wdata;
            if (int'(waddr) < 24) m24[waddr] <= wdata;
        end
    end

    function automatic logic [31:0] exp_rd(int n, logic [4:0] a);
        logic [31:0] v;
        if (clr || a == 5'd0 || int'(a) >= n) return 32'h0;
        v = (n == 32) ? m32[a] : m24[a];
        if (BYP && we && waddr == a) v = wdata;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act,
                         logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc32_a", if32.rdata_a, exp_rd(32, ra));
            check("cyc32_b", if32.rdata_b, exp_rd(32, rb));
            check("cyc24_a", if24.rdata_a, exp_rd(24, ra));
            check("cyc24_b", if24.rdata_b, exp_rd(24, rb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        we    = 1'b0;
        waddr = 5'd0;
        wdata = 32'h0;
        ra    = 5'd0;
        rb    = 5'd0;
        #12;
        clr = 1'b0;
        tick();
        check("reset_r1", if32.rdata_a, 32'h0);
        chk_on = 1'b1;

        for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFF_FFFF);
        ra = 5'd31;
        #1;
        check("preload", if32.rdata_a, 32'hFFFF_FFFF);

        // clr mid-cycle with a write pending across several edges
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'h0BAD_0BAD;
        #2;
        clr = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a);
            rb = 5'(31 - a);
            #1;
            check("clr_a", if32.rdata_a, 32'h0);
            check("clr_b", if32.rdata_b, 32'h0);
        end
        clr = 1'b0;
        ra  = 5'd9;
        #1;
        check("clr_drop", if32.rdata_a, 32'h0);
        tick();
        check("post_clr_wr", if32.rdata_a, 32'h0BAD_0BAD);
        we = 1'b0;

        wr(5'd5, 32'hDEAD_BEEF);
        ra = 5'd5;
        rb = 5'd6;
        #1;
        check("basic_a", if32.rdata_a, 32'hDEAD_BEEF);
        check("basic_b", if32.rdata_b, 32'h0);
        check("basic24", if24.rdata_a, 32'hDEAD_BEEF);

        wr(5'd0, 32'h1234_5678);
        ra = 5'd0;
        rb = 5'd0;
        #1;
        check("r0_a", if32.rdata_a, 32'h0);
        check("r0_b", if32.rdata_b, 32'h0);

        wr(5'd3, 32'hA5A5_A5A5);
        wr(5'd31, 32'h5A5A_5A5A);
        ra = 5'd3;
        rb = 5'd31;
        #1;
        check("dual_a", if32.rdata_a, 32'hA5A5_A5A5);
        check("dual_b", if32.rdata_b, 32'h5A5A_5A5A);
        check("oor24", if24.rdata_b, 32'h0);
        ra = 5'd31;
        #1;
        check("same_a", if32.rdata_a, 32'h5A5A_5A5A);
        check("same_b", if32.rdata_b, 32'h5A5A_5A5A);

        wr(5'd7, 32'h1);
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'h2;
        ra    = 5'd7;
        #1;
        check("rdw_pre", if32.rdata_a, BYP ? 32'h2 : 32'h1);
        tick();
        we = 1'b0;
        #1;
        check("rdw_post", if32.rdata_a, 32'h2);

        repeat (800) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            ra    = 5'($urandom_range(0, 31));
            rb    = ($urandom_range(0, 3) == 0) ? waddr
                                               : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                clr = 1'b1;
                #3;
                clr = 1'b0;
            end
            tick();
        end
        we = 1'b0;

        for (int a = 24; a < 32; a++) begin
            ra = 5'(a);
            #1;
            check("oor_rd24", if24.rdata_a, 32'h0);
        end
        for (int a = 1; a < 24; a++) begin
            rb = 5'(a);
            #1;
            check("row24", if24.rdata_b, m24[a]);
            check("row32", if32.rdata_b, m32[a]);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_tri.md
Name: regfile_tri

Overview:
- Multi-port register file: one synchronous write port, two combinational read ports.
- Storage is rows of enable-gated, async-clear flip-flops; read ports are shared tri-state buses driven by one row at a time.
- Sits between the decode stage (supplies read addresses) and writeback (supplies the write port) of the processor datapath.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, bits per register.
- NUM_REGS, 32, number of architectural registers including r0; must be at most 2**ADDR_WIDTH.
- ADDR_WIDTH, 5, width of every address port.

Ports:
- clk      input   1           clock; all writes on rising edge
- clr      input   1           reset, asynchronous, active-high
- we       input   1           write enable
- waddr    input   ADDR_WIDTH  write register index
- wdata    input   DATA_WIDTH  write data
- raddr_a  input   ADDR_WIDTH  read port A index
- raddr_b  input   ADDR_WIDTH  read port B index
- rdata_a  output  DATA_WIDTH  read port A data
- rdata_b  output  DATA_WIDTH  read port B data

Behaviour:
- Reset: clr high clears every row to 0 immediately, independent of clk. While clr is high, rdata_a and rdata_b read 0 for any address. Writes are ignored while clr is high.
- Reset mid-operation: a write coinciding with clr assertion is lost. The first write is accepted on the first rising edge after clr falls.
- Write, 1-cycle latency: at a rising clk with we=1, waddr in 1..NUM_REGS-1 and clr=0, row[waddr] <= wdata. All other rows hold their value.
- Writes to waddr=0 or waddr>=NUM_REGS are silently dropped.
- Write decode: waddr goes through a one-hot decoder ANDed with we to form per-row enables. At most one row is enabled per cycle.
- Read, 0-cycle latency: each port has its own one-hot decode of raddr_x. Row i drives the port bus only when its decode bit is set; otherwise it is high-Z.
- raddr_x=0 enables a constant-zero driver.
- raddr_x>=NUM_REGS enables the same zero driver (no floating bus).
- Bus rules: exactly one driver is active per port in every cycle, so no Z and no X on rdata_x after reset. The two ports decode independently; raddr_a==raddr_b is legal and both return the same value.
- Read-during-write, same index, no bypass: the read returns the old value until the edge and the new value after it.
- Width rule: wdata is stored exactly, with no sign extension or truncation.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when we=1, clr=0, waddr!=0 and waddr==raddr_x, rdata_x returns wdata combinationally in the same cycle, i.e. write-before-read forwarding for writeback→decode.
  - The bypass mux sits after the tri-state bus.
  - Bypass never applies to r0 or to out-of-range addresses; those still read 0.
- Undefined: no mux; behaviour exactly as in Behaviour.

Decomposition:
- Shared package regfile_pkg:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS defaults.
  - ZERO_REG index constant (0).
  - Typedefs reg_addr_t and reg_data_t.
- One sub-module, decoder_onehot (parameterised ADDR_WIDTH → 2**ADDR_WIDTH outputs, with enable input). Instantiated three times: write, read A, read B.
- Row storage uses the team's existing tri-state enable flip-flop cell; no new cell.

Test Plan:
- Reset: assert clr mid-cycle with all rows preloaded to 0xFFFFFFFF → every raddr 0..31 reads 0x00000000 before the next edge; a write on the same edge is discarded.
- Basic write/read: we=1, waddr=5, wdata=0xDEADBEEF, one edge → raddr_a=5 reads 0xDEADBEEF; raddr_b=6 reads 0.
- r0 protection: we=1, waddr=0, wdata=0x12345678 → raddr_a=0 and raddr_b=0 read 0x00000000.
- Dual port: write r3=0xA5A5A5A5 and r31=0x5A5A5A5A; raddr_a=3, raddr_b=31 → 0xA5A5A5A5 / 0x5A5A5A5A; raddr_a=raddr_b=31 → both 0x5A5A5A5A. No Z/X on either bus in any cycle.
- Read-during-write: r7=0x1, then we=1, waddr=7, wdata=0x2, raddr_a=7:
  - Macro undefined → 0x1 before the edge, 0x2 after.
  - REGFILE_BYPASS_EN → 0x2 in the same cycle.
- Sweep: random writes to all indices with a scoreboard, NUM_REGS=24 → reads of 24..31 return 0; writes to 24..31 do not alter any row.
